// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bundle: decode-side inputs, EX-slot outputs and
// the stall/flush handshake. The optional bubble_cnt member exists only when
// ID_EX_BUBBLE_CNT_EN is defined.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W   = 16,
  parameter int REG_ID_W = 4
);
  // Decode slot
  logic                id_valid;
  logic [DATA_W-1:0]   id_pc;
  logic [DATA_W-1:0]   id_instr;
  logic [REG_ID_W-1:0] id_src1_id;
  logic [REG_ID_W-1:0] id_src2_id;
  logic [REG_ID_W-1:0] id_dst_id;
  logic [DATA_W-1:0]   id_src1_data;
  logic [DATA_W-1:0]   id_src2_data;
  logic                id_uses_src1;
  logic                id_uses_src2;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_mem_write;

  // Pipeline control
  logic                flush;
  logic                ex_stall;
  logic                id_stall;

  // Execute slot
  logic                ex_valid;
  logic [DATA_W-1:0]   ex_pc;
  logic [DATA_W-1:0]   ex_instr;
  logic [REG_ID_W-1:0] ex_src1_id;
  logic [REG_ID_W-1:0] ex_src2_id;
  logic [REG_ID_W-1:0] ex_dst_id;
  logic [DATA_W-1:0]   ex_src1_data;
  logic [DATA_W-1:0]   ex_src2_data;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic                ex_mem_write;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0]         bubble_cnt;
`endif

  // Upstream/decode side: drives the decode slot, observes EX and stall.
  modport master (
    output id_valid, id_pc, id_instr, id_src1_id, id_src2_id, id_dst_id,
           id_src1_data, id_src2_data, id_uses_src1, id_uses_src2,
           id_reg_write, id_mem_read, id_mem_write, flush, ex_stall,
    input  id_stall, ex_valid, ex_pc, ex_instr, ex_src1_id, ex_src2_id,
           ex_dst_id, ex_src1_data, ex_src2_data, ex_reg_write,
           ex_mem_read, ex_mem_write
`ifdef ID_EX_BUBBLE_CNT_EN
    , input bubble_cnt
`endif
  );

  // The pipeline register itself.
  modport slave (
    input  id_valid, id_pc, id_instr, id_src1_id, id_src2_id, id_dst_id,
           id_src1_data, id_src2_data, id_uses_src1, id_uses_src2,
           id_reg_write, id_mem_read, id_mem_write, flush, ex_stall,
    output id_stall, ex_valid, ex_pc, ex_instr, ex_src1_id, ex_src2_id,
           ex_dst_id, ex_src1_data, ex_src2_data, ex_reg_write,
           ex_mem_read, ex_mem_write
`ifdef ID_EX_BUBBLE_CNT_EN
    , output bubble_cnt
`endif
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with load-use hazard detection.
// Update priority per edge: rst > flush (bubble) > ex_stall (hold) >
// hazard (bubble) > normal load. id_stall is purely combinational.
// Optional macro ID_EX_BUBBLE_CNT_EN adds a saturating 16-bit count of
// hazard bubbles (flush bubbles are not counted).
module id_ex_pipe_reg #(
  parameter int DATA_W   = 16,
  parameter int REG_ID_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_pipe_reg_if.slave   bus
);

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   instr;
    logic [REG_ID_W-1:0] src1Id;
    logic [REG_ID_W-1:0] src2Id;
    logic [REG_ID_W-1:0] dstId;
    logic [DATA_W-1:0]   src1Data;
    logic [DATA_W-1:0]   src2Data;
    logic                regWrite;
    logic                memRead;
    logic                memWrite;
  } exSlot_t;

  exSlot_t exQ;       // current EX slot
  exSlot_t exD;       // next EX slot
  exSlot_t idSlot;    // decode slot as it would enter EX
  logic    src1Match;
  logic    src2Match;
  logic    hazard;

  // Load-use hazard: a valid load in EX writing a non-zero register that
  // the decode instruction actually reads.
  always_comb begin
    src1Match = bus.id_uses_src1 && (bus.id_src1_id == exQ.dstId);
    src2Match = bus.id_uses_src2 && (bus.id_src2_id == exQ.dstId);
    hazard    = exQ.valid && exQ.memRead && (exQ.dstId != '0) &&
                bus.id_valid && (src1Match || src2Match);
  end

  assign bus.id_stall = hazard | bus.ex_stall;

  // Pack the decode slot; controls are gated so an empty slot never carries them.
  always_comb begin
    idSlot.valid    = bus.id_valid;
    idSlot.pc       = bus.id_pc;
    idSlot.instr    = bus.id_instr;
    idSlot.src1Id   = bus.id_src1_id;
    idSlot.src2Id   = bus.id_src2_id;
    idSlot.dstId    = bus.id_dst_id;
    idSlot.src1Data = bus.id_src1_data;
    idSlot.src2Data = bus.id_src2_data;
    idSlot.regWrite = bus.id_reg_write & bus.id_valid;
    idSlot.memRead  = bus.id_mem_read  & bus.id_valid;
    idSlot.memWrite = bus.id_mem_write & bus.id_valid;
  end

  // Next EX slot selection in priority order (reset handled in the register).
  always_comb begin
    // NOTE: default assigned first so every path drives exD and no latch is inferred.
    exD = exQ;
    if (bus.flush)         exD = '0;
    else if (bus.ex_stall) exD = exQ;
    else if (hazard)       exD = '0;
    else                   exD = idSlot;
  end

  // EX slot register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for state so all flops update together at the edge.
    if (rst) exQ <= '0;
    else     exQ <= exD;
  end

  assign bus.ex_valid     = exQ.valid;
  assign bus.ex_pc        = exQ.pc;
  assign bus.ex_instr     = exQ.instr;
  assign bus.ex_src1_id   = exQ.src1Id;
  assign bus.ex_src2_id   = exQ.src2Id;
  assign bus.ex_dst_id    = exQ.dstId;
  assign bus.ex_src1_data = exQ.src1Data;
  assign bus.ex_src2_data = exQ.src2Data;
  assign bus.ex_reg_write = exQ.regWrite;
  assign bus.ex_mem_read  = exQ.memRead;
  assign bus.ex_mem_write = exQ.memWrite;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubbleCnt;
  logic        hazardBubble;

  // Only a hazard bubble counts: flush and stall both take priority over it.
  assign hazardBubble = hazard & ~bus.flush & ~bus.ex_stall;

  // Saturating hazard-bubble counter.
  always_ff @(posedge clk) begin
    if (rst)                                 bubbleCnt <= '0;
    else if (hazardBubble && (bubbleCnt != 16'hFFFF)) bubbleCnt <= bubbleCnt + 16'd1;
  end

  assign bus.bubble_cnt = bubbleCnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg. The driver applies one directed vector
// per cycle and pushes the hand-determined id_stall value and EX-slot contents;
// the monitor pops and compares them independently.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DATA_W(16), .REG_ID_W(4)) bus ();

  id_ex_pipe_reg #(.DATA_W(16), .REG_ID_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  dst;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [3:0]  s1;
    logic [15:0] d1;
    logic [3:0]  s2;
    logic [15:0] d2;
    logic        u1;
    logic        u2;
    logic [3:0]  dst;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        flush;
    logic        exStall;
  } in_t;

  // Hand-chosen outcome of each edge.
  typedef enum logic [2:0] {K_RST, K_LOAD, K_HOLD, K_FLUSH, K_HAZ} kind_e;

  exp_t exQ[$];
  int   stallQ[$];      // -1 = do not check this cycle
  exp_t curExp;
  logic [15:0] expCnt;
  int   assertions = 0;
  int   failures   = 0;
  bit   driverDone = 1'b0;

  function automatic in_t mk(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                             input logic [3:0] s1, input logic [15:0] d1,
                             input logic [3:0] s2, input logic [15:0] d2,
                             input logic u1, input logic u2, input logic [3:0] dst,
                             input logic rw, input logic mr, input logic mw,
                             input logic fl, input logic st);
    in_t r;
    r.rst = 1'b0; r.valid = v; r.pc = pc; r.instr = ins;
    r.s1 = s1; r.d1 = d1; r.s2 = s2; r.d2 = d2; r.u1 = u1; r.u2 = u2;
    r.dst = dst; r.rw = rw; r.mr = mr; r.mw = mw; r.flush = fl; r.exStall = st;
    return r;
  endfunction

  function automatic exp_t loadOf(input in_t v);
    exp_t e;
    e.valid = v.valid; e.pc = v.pc; e.instr = v.instr;
    e.s1 = v.s1; e.s2 = v.s2; e.dst = v.dst; e.d1 = v.d1; e.d2 = v.d2;
    e.rw = v.rw & v.valid; e.mr = v.mr & v.valid; e.mw = v.mw & v.valid;
    e.cnt = 16'd0;
    return e;
  endfunction

  task automatic step(input in_t v, input int expStall, input kind_e k);
    @(negedge clk);
    #1;
    rst               = v.rst;
    bus.id_valid      = v.valid;
    bus.id_pc         = v.pc;
    bus.id_instr      = v.instr;
    bus.id_src1_id    = v.s1;
    bus.id_src1_data  = v.d1;
    bus.id_src2_id    = v.s2;
    bus.id_src2_data  = v.d2;
    bus.id_uses_src1  = v.u1;
    bus.id_uses_src2  = v.u2;
    bus.id_dst_id     = v.dst;
    bus.id_reg_write  = v.rw;
    bus.id_mem_read   = v.mr;
    bus.id_mem_write  = v.mw;
    bus.flush         = v.flush;
    bus.ex_stall      = v.exStall;
    case (k)
      K_RST:   begin expCnt = 16'd0; curExp = '0; end
      K_LOAD:  curExp = loadOf(v);
      K_HOLD:  ;
      K_FLUSH: curExp = '0;
      K_HAZ:   begin expCnt = expCnt + 16'd1; curExp = '0; end
      default: ;
    endcase
`ifdef ID_EX_BUBBLE_CNT_EN
    curExp.cnt = expCnt;
`else
    curExp.cnt = 16'd0;
`endif
    stallQ.push_back(expStall);
    exQ.push_back(curExp);
  endtask

  // Monitor: id_stall checked mid-low-phase, EX slot checked just after the edge.
  initial begin : monitor
    exp_t act;
    exp_t exp;
    int   s;
    forever begin
      @(negedge clk);
      #2;
      if (stallQ.size() > 0) begin
        s = stallQ.pop_front();
        if (s >= 0) begin
          assertions++;
          if (bus.id_stall !== s[0]) begin
            failures++;
            $display("FAIL id_stall @%0t: got %b expected %0d", $time, bus.id_stall, s);
          end
        end
      end
      @(posedge clk);
      #1;
      if (exQ.size() > 0) begin
        exp = exQ.pop_front();
        act.valid = bus.ex_valid;     act.pc = bus.ex_pc;       act.instr = bus.ex_instr;
        act.s1 = bus.ex_src1_id;      act.s2 = bus.ex_src2_id;  act.dst = bus.ex_dst_id;
        act.d1 = bus.ex_src1_data;    act.d2 = bus.ex_src2_data;
        act.rw = bus.ex_reg_write;    act.mr = bus.ex_mem_read; act.mw = bus.ex_mem_write;
`ifdef ID_EX_BUBBLE_CNT_EN
        act.cnt = bus.bubble_cnt;
`else
        act.cnt = 16'd0;
`endif
        assertions++;
        if (act !== exp) begin
          failures++;
          $display("FAIL ex_slot @%0t: got %h expected %h", $time, act, exp);
        end
      end
    end
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin : driver
    in_t r;
    in_t ld;
    in_t use1;
    in_t use2;
    for (int i = 0; i < 2; i++) begin
      r = in_t'({$urandom, $urandom, $urandom, $urandom});
      r.rst = 1'b1;
      r.exStall = 1'b0;
      step(r, (i == 0) ? -1 : 0, K_RST);
    end

    // Pass-through.
    step(mk(1, 16'h0010, 16'h1111, 4'd3, 16'h1234, 4'd4, 16'hBEEF, 1, 1, 4'd5, 1, 0, 0, 0, 0), 0, K_LOAD);
    // Load into R2, then a consumer of R2 -> one bubble, then it enters EX.
    step(mk(1, 16'h0012, 16'h2222, 4'd1, 16'h0001, 4'd0, 16'h0000, 1, 0, 4'd2, 1, 1, 0, 0, 0), 0, K_LOAD);
    use1 = mk(1, 16'h0014, 16'h3333, 4'd2, 16'hAAAA, 4'd7, 16'h5555, 1, 1, 4'd3, 1, 0, 0, 0, 0);
    step(use1, 1, K_HAZ);
    step(use1, 0, K_LOAD);
    // Load to R0 followed by a reader of R0: no hazard.
    step(mk(1, 16'h0016, 16'h4444, 4'd1, 16'h0101, 4'd0, 16'h0000, 1, 0, 4'd0, 1, 1, 0, 0, 0), 0, K_LOAD);
    step(mk(1, 16'h0018, 16'h5555, 4'd0, 16'h0000, 4'd1, 16'h0202, 1, 0, 4'd6, 1, 1, 0, 0, 0), 0, K_LOAD);
    // Load to R6 followed by an instruction naming R6 as unused src2: no hazard.
    step(mk(1, 16'h001A, 16'h6666, 4'd7, 16'h0303, 4'd6, 16'h0404, 1, 0, 4'd8, 1, 0, 0, 0, 0), 0, K_LOAD);
    // ex_stall for three cycles with changing decode fields: hold.
    step(mk(1, 16'h0100, 16'h7001, 4'd9, 16'h1001, 4'd10, 16'h2001, 1, 1, 4'd11, 1, 0, 1, 0, 1), 1, K_HOLD);
    step(mk(0, 16'h0102, 16'h7002, 4'd12, 16'h1002, 4'd13, 16'h2002, 0, 1, 4'd14, 0, 1, 0, 0, 1), 1, K_HOLD);
    step(mk(1, 16'h0104, 16'h7003, 4'd15, 16'h1003, 4'd1, 16'h2003, 1, 0, 4'd2, 1, 1, 1, 0, 1), 1, K_HOLD);
    // Invalid slot: data loads, controls gated off.
    step(mk(0, 16'h0200, 16'h8888, 4'd3, 16'hCAFE, 4'd4, 16'hF00D, 1, 1, 4'd5, 1, 1, 1, 0, 0), 0, K_LOAD);
    // Load to R9, then flush + stall + hazard together: squash, no count.
    step(mk(1, 16'h0202, 16'h9999, 4'd1, 16'h0011, 4'd2, 16'h0022, 1, 1, 4'd9, 1, 1, 0, 0, 0), 0, K_LOAD);
    step(mk(1, 16'h0204, 16'hAAAA, 4'd9, 16'h0033, 4'd2, 16'h0044, 1, 1, 4'd3, 1, 0, 0, 1, 1), 1, K_FLUSH);
    // Load to R10, then hazard on src2 under ex_stall (hold), then bubble, then entry.
    step(mk(1, 16'h0300, 16'hBBBB, 4'd1, 16'h0055, 4'd2, 16'h0066, 1, 1, 4'd10, 1, 1, 0, 0, 0), 0, K_LOAD);
    use2 = mk(1, 16'h0302, 16'hCCCC, 4'd3, 16'h0077, 4'd10, 16'h0088, 0, 1, 4'd4, 0, 0, 1, 0, 1);
    step(use2, 1, K_HOLD);
    use2.exStall = 1'b0;
    step(use2, 1, K_HAZ);
    step(use2, 0, K_LOAD);
    // Plain flush of a valid decode slot, then a normal load.
    step(mk(1, 16'h0304, 16'hDDDD, 4'd5, 16'h0099, 4'd6, 16'h00AA, 1, 1, 4'd7, 1, 0, 0, 1, 0), 0, K_FLUSH);
    ld = mk(1, 16'h0306, 16'hEEEE, 4'd8, 16'h00BB, 4'd9, 16'h00CC, 1, 1, 4'd12, 1, 1, 1, 0, 0);
    step(ld, 0, K_LOAD);
    driverDone = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then report.
  initial begin
    wait (driverDone);
    for (int i = 0; i < 10 && (exQ.size() > 0 || stallQ.size() > 0); i++) @(posedge clk);
    #2;
    if (exQ.size() > 0 || stallQ.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d ex / %0d stall entries left, expected 0", exQ.size(), stallQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
